// File: rtl/shared_timer_pkg.sv
// shared_timer_pkg: shared definitions for the shared_timer_arb block.
// Holds the FSM state encoding, default sizing and the req_len slice helper.
package shared_timer_pkg;

  // Default sizing for the timer scheduler.
  localparam int N_REQ_DEFAULT = 4;
  localparam int CNT_W_DEFAULT = 4;

  // Controller states. The encoding lives here so every user of the block agrees on it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Low bit of requester idx's length field inside a packed req_len bus.
  function automatic int len_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage : shared_timer_pkg

// File: rtl/shared_timer_arb_rr_arbiter.sv
// rr_arbiter: combinational winner select for the shared timer.
// With SHARED_TIMER_RR_EN defined the search starts at ptr_i and wraps;
// otherwise requester 0 has the highest fixed priority and no pointer input exists.
module rr_arbiter
  import shared_timer_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
`ifdef SHARED_TIMER_RR_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  output logic [N_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  // Pick the first pending requester in search order.
  always_comb begin
    // NOTE: every output and temporary gets a default first so no path leaves one unassigned (no latch).
    int  cand;
    logic found;
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef SHARED_TIMER_RR_EN
      cand = (int'(ptr_i) + k) % N_REQ;
`else
      cand = k;
`endif
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = IDX_W'(cand);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/shared_timer_arb.sv
// shared_timer_arb: time-multiplexes one down-counting interval timer among N_REQ requesters.
// Each grant lasts req_len+1 cycles, then the owner gets a one-cycle done pulse.
// All state changes on the falling edge of clk; rst is synchronous and active-high.
// Macro SHARED_TIMER_RR_EN selects round-robin arbitration (with pointer register);
// when undefined, requester 0 has fixed highest priority and no pointer is built.
module shared_timer_arb
  import shared_timer_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q,  done_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [N_REQ-1:0] win_onehot;
  logic [IDX_W-1:0] win_idx;

`ifdef SHARED_TIMER_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_next;

  // Pointer moves one past the finishing owner, wrapping at N_REQ.
  assign owner_next = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i    (req),
`ifdef SHARED_TIMER_RR_EN
    .ptr_i    (ptr_q),
`endif
    .onehot_o (win_onehot),
    .idx_o    (win_idx)
  );

  // Next-state logic: grant on request in IDLE, count down in RUN, pulse done on expiry.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    done_d  = '0;
    count_d = count_q;
`ifdef SHARED_TIMER_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_RUN;
          owner_d = win_idx;
          grant_d = win_onehot;
          // Length is captured only here; later req_len changes do not affect this interval.
          count_d = req_len[len_lo(int'(win_idx), CNT_W) +: CNT_W];
        end
      end
      ST_RUN: begin
        // Expiry is tested before withdrawal so a coincident drop still completes.
        if (count_q == '0) begin
          state_d = ST_DONE;
          done_d  = grant_q;
          grant_d = '0;
`ifdef SHARED_TIMER_RR_EN
          ptr_d   = owner_next;
`endif
        end else if (!req[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
`ifdef SHARED_TIMER_RR_EN
          ptr_d   = owner_next;
`endif
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register on the falling edge with synchronous reset.
  always_ff @(negedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
`ifdef SHARED_TIMER_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      count_q <= count_d;
`ifdef SHARED_TIMER_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);
  assign count = count_q;

endmodule : shared_timer_arb

// File: tb/tb_shared_timer_arb.sv
// tb_shared_timer_arb: self-checking bench for shared_timer_arb.
// A behavioural model tracks owner / remaining cycles / pending done pulse and is
// compared with the DUT every rising edge; directed sections add literal checks.
// Follows SHARED_TIMER_RR_EN the same way the RTL does.
module tb_shared_timer_arb;

  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*CW-1:0] req_len;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic [CW-1:0]   count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: owner (-1 none), cycles left on the counter, requester awaiting done (-1 none).
  int m_owner = -1;
  int m_left  = 0;
  int m_pulse = -1;
  int m_ptr   = 0;

  shared_timer_arb #(
    .N_REQ (N),
    .CNT_W (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_len (req_len),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner chosen from the arbitration rule stated for the build.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef SHARED_TIMER_RR_EN
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
`else
    for (int k = 0; k < N; k++) if (r[k] && ptr >= 0) return k;
`endif
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (rst) begin
      m_owner = -1; m_left = 0; m_pulse = -1; m_ptr = 0;
    end else if (m_pulse >= 0) begin
      m_pulse = -1;
    end else if (m_owner >= 0) begin
      if (m_left == 0) begin
        m_pulse = m_owner;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_left = m_left - 1;
      end
    end else if (req != '0) begin
      w       = pick(req, m_ptr);
      m_owner = w;
      m_left  = int'(req_len[w*CW +: CW]);
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  // Compare process: outputs are stable on the rising edge (DUT changes on falling edge).
  always @(posedge clk) begin
    if (chk_en) begin
      check("m_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("m_done",  32'(done),  (m_pulse >= 0) ? (32'd1 << m_pulse) : 32'd0);
      check("m_busy",  32'(busy),  32'((m_owner >= 0) || (m_pulse >= 0)));
      check("m_count", 32'(count), 32'(m_left));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rr_exp [5];
    logic [N-1:0] fp_exp [4];
    logic [N-1:0] flip;

    rst = 1'b1; req = '0; req_len = '0;
    step(); step(); step();
    check("rst_grant", 32'(grant), 0);
    check("rst_done",  32'(done),  0);
    check("rst_busy",  32'(busy),  0);
    check("rst_count", 32'(count), 0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Single request, len 3: four grant cycles counting 3..0, then done, then idle.
    req = 4'b0001; req_len = 16'h0003;
    step(); check("t1_grant", 32'(grant), 1); check("t1_busy", 32'(busy), 1);
    check("t1_cnt3", 32'(count), 3);
    step(); check("t1_cnt2", 32'(count), 2);
    step(); check("t1_cnt1", 32'(count), 1);
    step(); check("t1_cnt0", 32'(count), 0); check("t1_grant_last", 32'(grant), 1);
    step(); check("t1_done", 32'(done), 1); check("t1_grant_off", 32'(grant), 0);
    check("t1_busy_done", 32'(busy), 1);
    req = '0;
    step(); check("t1_done_off", 32'(done), 0); check("t1_busy_off", 32'(busy), 0);

    // All requesting with zero length: grants every 3 cycles.
`ifdef SHARED_TIMER_RR_EN
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fp_exp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
`else
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    fp_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
    do_reset();
    req = 4'b1111; req_len = '0;
    for (int i = 0; i < 5; i++) begin
      step(); check("all_req_grant", 32'(grant), 32'(rr_exp[i]));
      step(); step();
    end
    req = '0;

    do_reset();
    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step(); check("prio_grant", 32'(grant), 32'(fp_exp[i]));
      step(); step();
    end
    req = '0;

    // Abort: requester 2 drops after two RUN cycles; requester 3 is next.
    do_reset();
    req = 4'b1100; req_len = 16'h1500;
    step(); check("ab_grant", 32'(grant), 4'b0100); check("ab_cnt", 32'(count), 5);
    step(); step();
    req = 4'b1000;
    step(); check("ab_grant_off", 32'(grant), 0); check("ab_no_done", 32'(done), 0);
    check("ab_idle", 32'(busy), 0);
    step(); check("ab_next", 32'(grant), 4'b1000); check("ab_next_cnt", 32'(count), 1);
    step(); step(); check("ab_next_done", 32'(done), 4'b1000);
    req = '0;
    step();

    // Maximum length: 16 grant cycles counting 15..0 without wrap.
    do_reset();
    req = 4'b0001; req_len = 16'h000F;
    for (int k = 0; k < 16; k++) begin
      step();
      check("max_grant", 32'(grant), 1);
      check("max_cnt", 32'(count), 32'(15 - k));
    end
    step(); check("max_done", 32'(done), 1); check("max_cnt_end", 32'(count), 0);
    req = '0;
    step();

    // Withdrawal coincident with count 0: completion still wins.
    req = 4'b0010; req_len = 16'h0010;
    step(); check("co_grant", 32'(grant), 4'b0010);
    step(); check("co_cnt0", 32'(count), 0);
    req = '0;
    step(); check("co_done", 32'(done), 4'b0010);
    step();

    // Reset mid-RUN at count 2, after a completion that moved the pointer.
    do_reset();
    req = 4'b0001; req_len = '0;
    step(); step(); req = '0; step();
    req = 4'b0010; req_len = 16'h0040;
    step(); step(); step(); check("mr_cnt2", 32'(count), 2);
    rst = 1'b1;
    step();
    check("mr_grant", 32'(grant), 0); check("mr_done", 32'(done), 0);
    check("mr_busy", 32'(busy), 0); check("mr_count", 32'(count), 0);
    rst = 1'b0; req = 4'b1111;
    step(); check("mr_first", 32'(grant), 1);
    req = '0;
    step(); step();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      flip = '0;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 7) == 0);
      req     = req ^ flip;
      req_len = N*CW'($urandom);
      rst     = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_shared_timer_arb
